// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode stage: state encoding, instruction
// field positions and the default HALT opcode used by execute-stage decode.
package fetch_decode_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } fd_state_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] DEFAULT_HALT_OPCODE = 4'hF;

  function automatic logic [3:0] opcode_of(input logic [15:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// Fetch/decode stage: paces the program counter, waits out RAM read latency,
// latches each instruction and presents its fields over valid/ready.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int         RAM_LATENCY = 1,
  parameter logic [3:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_instruction,
  output logic        o_inc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [3:0]  o_opcode,
  output logic [1:0]  o_rd,
  output logic [1:0]  o_rs,
  output logic [7:0]  o_imm,
  output logic        o_halted,
  output logic [7:0]  o_fetch_count
);

  localparam logic [1:0] LAT_INIT = 2'(RAM_LATENCY);

  fd_state_e   state_r;
  logic [1:0]  wait_cnt_r;
  logic [15:0] ir_r;
  logic        valid_r;
  logic        halted_r;
  logic [7:0]  fetch_count_r;

  logic        accept_s;
  logic        is_halt_s;

  assign accept_s  = (state_r == ST_HOLD) & i_ready;
  assign is_halt_s = (opcode_of(ir_r) == HALT_OPCODE);

  // The counter samples o_inc on the accept edge, so it must be combinational.
  assign o_inc = accept_s & ~is_halt_s;

  assign o_valid       = valid_r;
  assign o_halted      = halted_r;
  assign o_fetch_count = fetch_count_r;
  assign o_opcode      = ir_r[OPC_MSB:OPC_LSB];
  assign o_rd          = ir_r[RD_MSB:RD_LSB];
  assign o_rs          = ir_r[RS_MSB:RS_LSB];
  assign o_imm         = ir_r[IMM_MSB:IMM_LSB];

  // Fetch sequencing: latency countdown, IR capture, handshake and halt.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= ST_FILL;
      wait_cnt_r    <= LAT_INIT;
      ir_r          <= 16'h0000;
      valid_r       <= 1'b0;
      halted_r      <= 1'b0;
      fetch_count_r <= 8'd0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (wait_cnt_r != 2'd0) begin
            wait_cnt_r <= wait_cnt_r - 2'd1;
          end else begin
            ir_r          <= i_instruction;
            fetch_count_r <= fetch_count_r + 8'd1;
            valid_r       <= 1'b1;
            state_r       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (accept_s) begin
            valid_r <= 1'b0;
            if (is_halt_s) begin
              halted_r <= 1'b1;
              state_r  <= ST_HALTED;
            end else begin
              wait_cnt_r <= LAT_INIT;
              state_r    <= ST_FILL;
            end
          end else begin
            valid_r <= 1'b1;
          end
        end
        ST_HALTED: begin
          valid_r  <= 1'b0;
          halted_r <= 1'b1;
        end
        default: begin
          // Unreachable encoding: restart the fetch sequence.
          valid_r    <= 1'b0;
          halted_r   <= 1'b0;
          wait_cnt_r <= LAT_INIT;
          state_r    <= ST_FILL;
        end
      endcase
    end
  end

endmodule
